// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word-addressed SRAM array. One transaction at a time,
// with INCR/FIXED bursts of up to 16 beats and configurable read/write response latency.
module axi_sram_slave #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 0,
    parameter int WR_LAT = 0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, WR_RESP} state_t;

    state_t            state, state_nxt;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [3:0]        beat_cnt, lat_cnt;
    logic              fixed, err, wr_prio;
    logic              ar_hs, aw_hs, r_hs, w_hs, b_hs, last_beat;
    logic              unused_ok;

    assign ar_hs     = arvalid & arready;
    assign aw_hs     = awvalid & awready;
    assign r_hs      = rvalid & rready;
    assign w_hs      = wvalid & wready;
    assign b_hs      = bvalid & bready;
    assign last_beat = (beat_cnt == 4'd0);
    assign addr_nxt  = fixed ? addr : addr + ADDR_W'(1);
    assign unused_ok = ^{araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0],
                         arlen[7:4], awlen[7:4], arsize};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs)      state_nxt = (RD_LAT == 0) ? RD_DATA : RD_WAIT;
                     else if (aw_hs) state_nxt = WR_DATA;
            RD_WAIT: if (lat_cnt == 4'd1) state_nxt = RD_DATA;
            RD_DATA: if (r_hs && last_beat) state_nxt = IDLE;
            WR_DATA: if (w_hs && last_beat) state_nxt = (WR_LAT == 0) ? WR_RESP : WR_WAIT;
            WR_WAIT: if (lat_cnt == 4'd1) state_nxt = WR_RESP;
            WR_RESP: if (bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        if (state == IDLE && !areset) begin
            if (arvalid && awvalid) begin
                arready = ~wr_prio;
                awready = wr_prio;
            end else begin
                arready = arvalid;
                awready = awvalid;
            end
        end
        rvalid = (state == RD_DATA);
        rlast  = rvalid && last_beat;
        rresp  = 2'b00;
        wready = (state == WR_DATA);
        bvalid = (state == WR_RESP);
        bresp  = (bvalid && err) ? 2'b10 : 2'b00;
    end

    // Priority only moves on contested grants, so the loser of a tie wins the next tie.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr     <= '0;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            fixed    <= 1'b0;
            err      <= 1'b0;
            wr_prio  <= 1'b0;
            rid      <= '0;
            bid      <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        rid      <= arid;
                        addr     <= araddr[ADDR_W+1:2];
                        beat_cnt <= arlen[3:0];
                        fixed    <= (arburst == 2'b00);
                        lat_cnt  <= 4'(RD_LAT);
                        rdata    <= mem[araddr[ADDR_W+1:2]];
                        if (awvalid) wr_prio <= ~wr_prio;
                    end else if (aw_hs) begin
                        bid      <= awid;
                        addr     <= awaddr[ADDR_W+1:2];
                        beat_cnt <= awlen[3:0];
                        fixed    <= (awburst == 2'b00);
                        err      <= 1'b0;
                        if (arvalid) wr_prio <= ~wr_prio;
                    end
                end
                RD_WAIT, WR_WAIT: lat_cnt <= lat_cnt - 4'd1;
                RD_DATA: begin
                    if (r_hs && !last_beat) begin
                        addr     <= addr_nxt;
                        beat_cnt <= beat_cnt - 4'd1;
                        rdata    <= mem[addr_nxt];
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        addr     <= addr_nxt;
                        beat_cnt <= beat_cnt - 4'd1;
                        lat_cnt  <= 4'(WR_LAT);
                        if (wlast != last_beat) err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array has no reset; its contents survive areset by design.
    always_ff @(posedge aclk) begin
        if (w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: two instances (zero latency and RD_LAT=3/WR_LAT=2)
// share one stimulus bus, selected by sel.
module tb_axi_sram_slave;

    localparam int BUDGET = 64;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        sel = 1'b0;
    logic [3:0]  arid = '0, awid = '0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01, awburst = 2'b01;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic        rready = 1'b0, bready = 1'b0;

    logic        arready, awready, rlast, rvalid, wready, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        arready0, awready0, rlast0, rvalid0, wready0, bvalid0;
    logic        arready1, awready1, rlast1, rvalid1, wready1, bvalid1;
    logic [3:0]  rid0, bid0, rid1, bid1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  rresp0, bresp0, rresp1, bresp1;

    int checks = 0, failures = 0, cyc = 0;
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf [16];
    logic        rlast_buf [16];
    logic [3:0]  rid_buf [16];
    logic [1:0]  rresp_buf [16];
    int          rcount, rlat, blat, stall_bad;
    logic [1:0]  last_bresp;
    logic [3:0]  last_bid;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    axi_sram_slave #(.ADDR_W(16), .RD_LAT(0), .WR_LAT(0)) dut0 (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid & ~sel), .arready(arready0),
        .rid(rid0), .rdata(rdata0), .rresp(rresp0), .rlast(rlast0), .rvalid(rvalid0),
        .rready(rready & ~sel),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid & ~sel), .awready(awready0),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid & ~sel), .wready(wready0),
        .bid(bid0), .bresp(bresp0), .bvalid(bvalid0), .bready(bready & ~sel)
    );

    axi_sram_slave #(.ADDR_W(16), .RD_LAT(3), .WR_LAT(2)) dut1 (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid & sel), .arready(arready1),
        .rid(rid1), .rdata(rdata1), .rresp(rresp1), .rlast(rlast1), .rvalid(rvalid1),
        .rready(rready & sel),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid & sel), .awready(awready1),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid & sel), .wready(wready1),
        .bid(bid1), .bresp(bresp1), .bvalid(bvalid1), .bready(bready & sel)
    );

    assign arready = sel ? arready1 : arready0;
    assign awready = sel ? awready1 : awready0;
    assign rlast   = sel ? rlast1   : rlast0;
    assign rvalid  = sel ? rvalid1  : rvalid0;
    assign wready  = sel ? wready1  : wready0;
    assign bvalid  = sel ? bvalid1  : bvalid0;
    assign rid     = sel ? rid1     : rid0;
    assign bid     = sel ? bid1     : bid0;
    assign rdata   = sel ? rdata1   : rdata0;
    assign rresp   = sel ? rresp1   : rresp0;
    assign bresp   = sel ? bresp1   : bresp0;

    task automatic timeout_fail(input string what);
        checks++; failures++;
        $display("FAIL %s: no handshake seen, required within %0d cycles", what, BUDGET);
    endtask

    task automatic reset_pulse();
        areset = 1'b1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [3:0] id,
                            input logic [1:0] burst, input int last_pos);
        bit ok;
        int wend;
        awaddr = a; awlen = {4'b0, len}; awid = id; awburst = burst; awvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge aclk);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("aw_handshake");
        @(posedge aclk); #1 awvalid = 1'b0;
        wend = cyc;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == last_pos); wvalid = 1'b1;
            ok = 0;
            for (int i = 0; i < BUDGET; i++) begin
                @(negedge aclk);
                if (wready) begin ok = 1; break; end
            end
            if (!ok) timeout_fail("w_handshake");
            wend = cyc;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge aclk);
            if (bvalid) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("b_handshake");
        last_bresp = bresp; last_bid = bid; blat = cyc - wend;
        @(posedge aclk); #1 bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [3:0] id,
                           input logic [1:0] burst, input bit toggle);
        bit ok, done, held_valid;
        int acc;
        logic [31:0] held;
        araddr = a; arlen = {4'b0, len}; arid = id; arburst = burst; arvalid = 1'b1;
        rready = 1'b1;
        ok = 0; acc = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge aclk);
            if (arready) begin ok = 1; acc = cyc; break; end
        end
        if (!ok) timeout_fail("ar_handshake");
        @(posedge aclk); #1 arvalid = 1'b0;
        rcount = 0; rlat = -1; stall_bad = 0; held_valid = 0; held = '0; done = 0;
        for (int i = 0; i < BUDGET && !done; i++) begin
            @(negedge aclk);
            if (rvalid) begin
                if (rlat < 0) rlat = cyc - acc;
                if (held_valid && rdata !== held) stall_bad++;
                if (rready) begin
                    rbuf[rcount] = rdata; rlast_buf[rcount] = rlast;
                    rid_buf[rcount] = rid; rresp_buf[rcount] = rresp;
                    rcount++; held_valid = 0;
                    if (rlast || rcount > int'(len)) done = 1;
                end else begin
                    held = rdata; held_valid = 1;
                end
            end
            @(posedge aclk); #1;
            if (toggle) rready = ~rready;
        end
        if (!done) timeout_fail("r_beats");
        rready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1; arvalid = 1'b1; awvalid = 1'b1;
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1); #1;
            checks++;
            if ({arready, awready, rvalid, rlast, wready, bvalid} !== 6'b0) begin
                failures++;
                $display("FAIL reset_handshake sel=%0d: got %b want 000000", s,
                         {arready, awready, rvalid, rlast, wready, bvalid});
            end
            checks++;
            if ({rid, bid, rdata, bresp} !== 42'b0) begin
                failures++;
                $display("FAIL reset_data sel=%0d: rid=%h bid=%h rdata=%h bresp=%b want all 0",
                         s, rid, bid, rdata, bresp);
            end
        end
        sel = 1'b0;
        reset_pulse();
    endtask

    task automatic test_single_read();
        sel = 1'b0;
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(32'h40, 4'd0, 4'd1, 2'b01, 0);
        do_read(32'h40, 4'd0, 4'd1, 2'b01, 0);
        checks++;
        if (rlat !== 1) begin failures++; $display("FAIL single_read_latency: got %0d want 1", rlat); end
        checks++;
        if (rbuf[0] !== 32'hDEADBEEF || rcount !== 1) begin
            failures++; $display("FAIL single_read_data: got %h (%0d beats) want deadbeef (1)", rbuf[0], rcount);
        end
        checks++;
        if ({rid_buf[0], rlast_buf[0], rresp_buf[0]} !== {4'd1, 1'b1, 2'b00}) begin
            failures++;
            $display("FAIL single_read_attrs: rid=%h rlast=%b rresp=%b want 1 1 00",
                     rid_buf[0], rlast_buf[0], rresp_buf[0]);
        end
    endtask

    task automatic test_icache_refill();
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA5A50040 + i; sbuf[i] = 4'hF; end
        do_write(32'h1C000100, 4'd3, 4'd2, 2'b01, 3);
        checks++;
        if ({last_bresp, last_bid} !== {2'b00, 4'd2} || blat !== 3) begin
            failures++;
            $display("FAIL refill_preload_b: bresp=%b bid=%h lat=%0d want 00 2 3", last_bresp, last_bid, blat);
        end
        do_read(32'h1C000100, 4'd3, 4'd0, 2'b01, 1);
        checks++;
        if (rlat !== 4) begin failures++; $display("FAIL refill_latency: got %0d want 4", rlat); end
        checks++;
        if (rcount !== 4) begin failures++; $display("FAIL refill_beats: got %0d want 4", rcount); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rbuf[i] !== 32'hA5A50040 + i || rlast_buf[i] !== (i == 3) || rid_buf[i] !== 4'd0) begin
                failures++;
                $display("FAIL refill_beat%0d: data=%h rlast=%b rid=%h want %h %b 0", i,
                         rbuf[i], rlast_buf[i], rid_buf[i], 32'hA5A50040 + i, (i == 3));
            end
        end
        checks++;
        if (stall_bad !== 0) begin failures++; $display("FAIL refill_stall_hold: got %0d changes want 0", stall_bad); end
        sel = 1'b0;
    endtask

    task automatic test_dcache_write();
        logic [31:0] exp [4];
        sel = 1'b0;
        exp[0] = 32'h01234567; exp[1] = 32'h89ABCDEF; exp[2] = 32'hFEDCBA98; exp[3] = 32'h76543210;
        for (int i = 0; i < 4; i++) begin wbuf[i] = exp[i]; sbuf[i] = 4'hF; end
        do_write(32'h200, 4'd3, 4'd9, 2'b01, 3);
        checks++;
        if ({last_bresp, last_bid} !== {2'b00, 4'd9} || blat !== 1) begin
            failures++;
            $display("FAIL dcache_b: bresp=%b bid=%h lat=%0d want 00 9 1", last_bresp, last_bid, blat);
        end
        do_read(32'h200, 4'd3, 4'd1, 2'b01, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rbuf[i] !== exp[i] || rlast_buf[i] !== (i == 3) || rid_buf[i] !== 4'd1) begin
                failures++;
                $display("FAIL dcache_readback%0d: data=%h rlast=%b rid=%h want %h %b 1", i,
                         rbuf[i], rlast_buf[i], rid_buf[i], exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_byte_strobe();
        sel = 1'b0;
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(32'h80, 4'd0, 4'd0, 2'b01, 0);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(32'h80, 4'd0, 4'd0, 2'b01, 0);
        do_read(32'h80, 4'd0, 4'd0, 2'b01, 0);
        checks++;
        if (rbuf[0] !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_0101: got %h want 11bb33dd", rbuf[0]); end
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'b0000;
        do_write(32'h80, 4'd0, 4'd0, 2'b01, 0);
        do_read(32'h80, 4'd0, 4'd0, 2'b01, 0);
        checks++;
        if (rbuf[0] !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_0000: got %h want 11bb33dd", rbuf[0]); end
    endtask

    task automatic test_burst_modes();
        sel = 1'b0;
        wbuf[0] = 32'h00000C00; wbuf[1] = 32'h00000C01; sbuf[0] = 4'hF; sbuf[1] = 4'hF; sbuf[2] = 4'hF;
        do_write(32'h300, 4'd1, 4'd0, 2'b01, 1);
        wbuf[0] = 32'hF0; wbuf[1] = 32'hF1; wbuf[2] = 32'hF2;
        do_write(32'h300, 4'd2, 4'd0, 2'b00, 2);
        do_read(32'h300, 4'd1, 4'd0, 2'b11, 0);
        checks++;
        if (rbuf[0] !== 32'hF2 || rbuf[1] !== 32'hC01) begin
            failures++; $display("FAIL fixed_write: got %h %h want f2 c01", rbuf[0], rbuf[1]);
        end
        do_read(32'h304, 4'd2, 4'd0, 2'b00, 0);
        checks++;
        if (rbuf[0] !== 32'hC01 || rbuf[1] !== 32'hC01 || rbuf[2] !== 32'hC01 || rcount !== 3) begin
            failures++; $display("FAIL fixed_read: got %h %h %h (%0d beats) want c01 x3", rbuf[0], rbuf[1], rbuf[2], rcount);
        end
        wbuf[0] = 32'hEEEE0001; wbuf[1] = 32'hEEEE0002;
        do_write(32'h3FFFC, 4'd1, 4'd0, 2'b01, 1);
        do_read(32'h0, 4'd0, 4'd0, 2'b01, 0);
        checks++;
        if (rbuf[0] !== 32'hEEEE0002) begin failures++; $display("FAIL addr_wrap: got %h want eeee0002", rbuf[0]); end
    endtask

    task automatic test_arbitration();
        sel = 1'b0;
        reset_pulse();
        wbuf[0] = 32'h5A5A0001; sbuf[0] = 4'hF;
        awaddr = 32'h400; awlen = '0; awid = 4'd3; awburst = 2'b01; awvalid = 1'b1;
        araddr = 32'h40; arlen = '0; arid = 4'd1; arburst = 2'b01; arvalid = 1'b1;
        #1;
        checks++;
        if ({arready, awready} !== 2'b10) begin
            failures++; $display("FAIL arb_first_pair: arready/awready=%b want 10", {arready, awready});
        end
        do_read(32'h40, 4'd0, 4'd1, 2'b01, 0);
        checks++;
        if (rbuf[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL arb_read_data: got %h want deadbeef", rbuf[0]); end
        do_write(32'h400, 4'd0, 4'd3, 2'b01, 0);
        wbuf[0] = 32'h5A5A0002;
        awaddr = 32'h404; awid = 4'd4; awvalid = 1'b1;
        araddr = 32'h400; arlen = 8'd1; arvalid = 1'b1;
        #1;
        checks++;
        if ({arready, awready} !== 2'b01) begin
            failures++; $display("FAIL arb_second_pair: arready/awready=%b want 01", {arready, awready});
        end
        do_write(32'h404, 4'd0, 4'd4, 2'b01, 0);
        do_read(32'h400, 4'd1, 4'd1, 2'b01, 0);
        checks++;
        if (rbuf[0] !== 32'h5A5A0001 || rbuf[1] !== 32'h5A5A0002) begin
            failures++; $display("FAIL arb_read_after_writes: got %h %h want 5a5a0001 5a5a0002", rbuf[0], rbuf[1]);
        end
    endtask

    task automatic test_wlast_error();
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hE0 + i; sbuf[i] = 4'hF; end
        do_write(32'h500, 4'd3, 4'd6, 2'b01, 1);
        checks++;
        if ({last_bresp, last_bid} !== {2'b10, 4'd6}) begin
            failures++; $display("FAIL early_wlast_b: bresp=%b bid=%h want 10 6", last_bresp, last_bid);
        end
        do_read(32'h500, 4'd3, 4'd0, 2'b01, 0);
        checks++;
        if (rbuf[3] !== 32'hE3 || rbuf[0] !== 32'hE0) begin
            failures++; $display("FAIL early_wlast_beats: word0=%h word3=%h want e0 e3", rbuf[0], rbuf[3]);
        end
        wbuf[0] = 32'h77; do_write(32'h510, 4'd0, 4'd6, 2'b01, -1);
        checks++;
        if (last_bresp !== 2'b10) begin failures++; $display("FAIL missing_wlast: bresp=%b want 10", last_bresp); end
        do_write(32'h510, 4'd0, 4'd6, 2'b01, 0);
        checks++;
        if (last_bresp !== 2'b00) begin failures++; $display("FAIL error_cleared: bresp=%b want 00", last_bresp); end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        sel = 1'b0;
        araddr = 32'h500; arlen = 8'd3; arid = 4'd1; arburst = 2'b01; rready = 1'b0; arvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge aclk);
            if (rvalid) begin ok = 1; break; end
            if (arready) begin @(posedge aclk); #1 arvalid = 1'b0; end
        end
        if (!ok) timeout_fail("mid_read_rvalid");
        #2 areset = 1'b1; arvalid = 1'b1;
        #1;
        checks++;
        if ({rvalid, rlast, arready} !== 3'b000) begin
            failures++; $display("FAIL reset_mid_read: rvalid/rlast/arready=%b want 000", {rvalid, rlast, arready});
        end
        arvalid = 1'b0;
        @(posedge aclk); #1 areset = 1'b0;
        do_read(32'h500, 4'd0, 4'd2, 2'b01, 0);
        checks++;
        if (rbuf[0] !== 32'hE0 || rlat !== 1 || rlast_buf[0] !== 1'b1 || rid_buf[0] !== 4'd2) begin
            failures++;
            $display("FAIL read_after_reset: data=%h lat=%0d rlast=%b rid=%h want e0 1 1 2",
                     rbuf[0], rlat, rlast_buf[0], rid_buf[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_icache_refill();
        test_dcache_write();
        test_byte_strobe();
        test_burst_modes();
        test_arbitration();
        test_wlast_error();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
